// File: rtl/roulette_round_sequencer_if.sv
// Bus between the PS/2/Arduino bet front end, the processor spin handshake and
// the round sequencer. The sequencer attaches through the slave modport.
interface roulette_round_sequencer_if;
  logic       key_valid;
  logic [5:0] bet_opcode;
  logic [2:0] color;
  logic       spin_done;
  logic [5:0] result_number;
  logic       bet_we;
  logic [3:0] bet_slot;
  logic [7:0] bet_data;
  logic [3:0] bet_count;
  logic       spin_req;
  logic       bets_clear;
  logic [5:0] win_number;
  logic [1:0] phase;
  logic       timeout_err;

  modport master (
    output key_valid, bet_opcode, color, spin_done, result_number,
    input  bet_we, bet_slot, bet_data, bet_count, spin_req, bets_clear,
           win_number, phase, timeout_err
  );

  modport slave (
    input  key_valid, bet_opcode, color, spin_done, result_number,
    output bet_we, bet_slot, bet_data, bet_count, spin_req, bets_clear,
           win_number, phase, timeout_err
  );
endinterface

// File: rtl/roulette_round_sequencer.sv
// Round FSM owning bet slots, spin request, result hold and slot clearing.
// Optional SPIN watchdog enabled by defining ROUND_TIMEOUT_EN.
module roulette_round_sequencer #(
  parameter int         MAX_BETS     = 12,
  parameter logic [5:0] OPC_SPIN     = 6'b111110,
  parameter logic [5:0] OPC_CLEAR    = 6'b111111,
  parameter int         HOLD_CYCLES  = 100_000_000,
  parameter int         SPIN_TIMEOUT = 200_000_000
) (
  input logic                          clock,
  input logic                          reset,
  roulette_round_sequencer_if.slave    bus
);

  localparam logic [1:0] ST_BET    = 2'd0;
  localparam logic [1:0] ST_SPIN   = 2'd1;
  localparam logic [1:0] ST_RESULT = 2'd2;
  localparam logic [1:0] ST_CLEAR  = 2'd3;

  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  // RESULT lasts exactly HOLD_CYCLES cycles, so the counter runs HOLD_CYCLES-1 .. 0.
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);

  if (MAX_BETS < 1 || MAX_BETS > 15 || HOLD_CYCLES < 1 || SPIN_TIMEOUT < 1) begin : g_bad_cfg
    $error("roulette_round_sequencer: illegal parameter combination");
  end

  logic [1:0]        state_q, state_d;
  logic [3:0]        count_q, count_d;
  logic              we_q, we_d;
  logic [3:0]        slot_q, slot_d;
  logic [7:0]        data_q, data_d;
  logic [5:0]        win_q, win_d;
  logic [HOLD_W-1:0] hold_q, hold_d;

`ifdef ROUND_TIMEOUT_EN
  localparam int WD_W = (SPIN_TIMEOUT > 1) ? $clog2(SPIN_TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(SPIN_TIMEOUT - 1);
  logic [WD_W-1:0] wd_q, wd_d;
  logic            tmo_q, tmo_d;
`endif

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    we_d    = 1'b0;
    slot_d  = slot_q;
    data_d  = data_q;
    win_d   = win_q;
    hold_d  = hold_q;
`ifdef ROUND_TIMEOUT_EN
    wd_d    = '0;
    tmo_d   = tmo_q;
`endif
    case (state_q)
      ST_BET: begin
        if (bus.key_valid) begin
          if (bus.bet_opcode == OPC_CLEAR) begin
            state_d = ST_CLEAR;
          end else if (bus.bet_opcode == OPC_SPIN) begin
            if (count_q != 4'd0) state_d = ST_SPIN;
          end else if (bus.color != 3'b000 && count_q < 4'(MAX_BETS)) begin
            we_d    = 1'b1;
            slot_d  = count_q;
            data_d  = {bus.color[1:0], bus.bet_opcode};
            count_d = count_q + 4'd1;
`ifdef ROUND_TIMEOUT_EN
            tmo_d   = 1'b0;
`endif
          end
        end
      end
      ST_SPIN: begin
        if (bus.spin_done) begin
          win_d   = bus.result_number;
          hold_d  = HOLD_LOAD;
          state_d = ST_RESULT;
        end
`ifdef ROUND_TIMEOUT_EN
        else if (wd_q == WD_LAST) begin
          tmo_d   = 1'b1;
          state_d = ST_CLEAR;
        end else begin
          wd_d = wd_q + 1'b1;
        end
`endif
      end
      ST_RESULT: begin
        if (hold_q == '0) state_d = ST_CLEAR;
        else              hold_d  = hold_q - 1'b1;
      end
      default: begin
        count_d = 4'd0;
        state_d = ST_BET;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= ST_BET;
      count_q <= 4'd0;
      we_q    <= 1'b0;
      slot_q  <= 4'd0;
      data_q  <= 8'd0;
      win_q   <= 6'd0;
      hold_q  <= '0;
`ifdef ROUND_TIMEOUT_EN
      wd_q    <= '0;
      tmo_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      we_q    <= we_d;
      slot_q  <= slot_d;
      data_q  <= data_d;
      win_q   <= win_d;
      hold_q  <= hold_d;
`ifdef ROUND_TIMEOUT_EN
      wd_q    <= wd_d;
      tmo_q   <= tmo_d;
`endif
    end
  end

  assign bus.bet_we     = we_q;
  assign bus.bet_slot   = slot_q;
  assign bus.bet_data   = data_q;
  assign bus.bet_count  = count_q;
  assign bus.spin_req   = (state_q == ST_SPIN);
  assign bus.bets_clear = (state_q == ST_CLEAR);
  assign bus.win_number = win_q;
  assign bus.phase      = state_q;
`ifdef ROUND_TIMEOUT_EN
  assign bus.timeout_err = tmo_q;
`else
  assign bus.timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_roulette_round_sequencer.sv
// Bench for roulette_round_sequencer: directed table, corner sequences, then
// random traffic against a queue-based round model.
module tb_roulette_round_sequencer;
  localparam int         MAX_BETS  = 12;
  localparam int         HOLD      = 4;
  localparam logic [5:0] OPC_SPIN  = 6'b111110;
  localparam logic [5:0] OPC_CLEAR = 6'b111111;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  roulette_round_sequencer_if bus();

  roulette_round_sequencer #(
    .MAX_BETS    (MAX_BETS),
    .OPC_SPIN    (OPC_SPIN),
    .OPC_CLEAR   (OPC_CLEAR),
    .HOLD_CYCLES (HOLD)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int n_vec  = 0;
  int n_fail = 0;

  // Reference model: the round as a phase number, a queue of accepted bets
  // and the absolute edge at which the result display ends.
  int         m_phase;
  logic [7:0] m_bets[$];
  int         m_clr_at;
  int         edge_n = 0;
  logic       m_we;
  logic [3:0] m_slot;
  logic [7:0] m_data;
  logic [5:0] m_win;

  task automatic model_edge(input logic rst_n, input logic kv, input logic [5:0] op,
                            input logic [2:0] col, input logic sd, input logic [5:0] rn);
    m_we = 1'b0;
    if (!rst_n) begin
      m_phase = 0;
      m_bets.delete();
      m_slot = 4'd0;
      m_data = 8'd0;
      m_win  = 6'd0;
    end else begin
      case (m_phase)
        0: if (kv) begin
          if (op == OPC_CLEAR) m_phase = 3;
          else if (op == OPC_SPIN) begin
            if (m_bets.size() > 0) m_phase = 1;
          end else if (col != 3'b000 && m_bets.size() < MAX_BETS) begin
            m_slot = 4'(m_bets.size());
            m_data = {col[1:0], op};
            m_bets.push_back(m_data);
            m_we = 1'b1;
          end
        end
        1: if (sd) begin
          m_win    = rn;
          m_phase  = 2;
          m_clr_at = edge_n + HOLD;
        end
        2: if (edge_n == m_clr_at) m_phase = 3;
        default: begin
          m_bets.delete();
          m_phase = 0;
        end
      endcase
    end
    edge_n++;
  endtask

  task automatic apply(input logic rst_n, input logic kv, input logic [5:0] op,
                       input logic [2:0] col, input logic sd, input logic [5:0] rn);
    reset             = rst_n;
    bus.key_valid     = kv;
    bus.bet_opcode    = op;
    bus.color         = col;
    bus.spin_done     = sd;
    bus.result_number = rn;
    model_edge(rst_n, kv, op, col, sd, rn);
    @(posedge clock);
    #1;
  endtask

  // Observation bundle; slot/data only meaningful when a write is expected.
  function automatic logic [27:0] observe(input logic exp_we);
    return {bus.bet_we, exp_we ? bus.bet_slot : 4'd0, exp_we ? bus.bet_data : 8'd0,
            bus.bet_count, bus.phase, bus.spin_req, bus.bets_clear,
            bus.win_number, bus.timeout_err};
  endfunction

  function automatic logic [27:0] expect_obs(input logic we, input logic [3:0] slot,
                                             input logic [7:0] data, input logic [3:0] cnt,
                                             input logic [1:0] ph, input logic [5:0] win);
    return {we, we ? slot : 4'd0, we ? data : 8'd0, cnt, ph,
            (ph == 2'd1), (ph == 2'd3), win, 1'b0};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, wanted %0h", name, act, exp);
    end
  endtask

  task automatic check_model(input string name);
    check(name, 32'(observe(m_we)),
          32'(expect_obs(m_we, m_slot, m_data, 4'(m_bets.size()), 2'(m_phase), m_win)));
  endtask

  typedef struct {
    logic       rst_n, kv;
    logic [5:0] op;
    logic [2:0] col;
    logic       sd;
    logic [5:0] rn;
    logic       e_we;
    logic [3:0] e_slot;
    logic [7:0] e_data;
    logic [3:0] e_cnt;
    logic [1:0] e_ph;
    logic [5:0] e_win;
  } vec_t;

  function automatic vec_t mk(input logic rst_n, input logic kv, input logic [5:0] op,
                              input logic [2:0] col, input logic sd, input logic [5:0] rn,
                              input logic e_we, input logic [3:0] e_slot, input logic [7:0] e_data,
                              input logic [3:0] e_cnt, input logic [1:0] e_ph, input logic [5:0] e_win);
    vec_t v;
    v.rst_n = rst_n; v.kv = kv; v.op = op; v.col = col; v.sd = sd; v.rn = rn;
    v.e_we = e_we; v.e_slot = e_slot; v.e_data = e_data;
    v.e_cnt = e_cnt; v.e_ph = e_ph; v.e_win = e_win;
    return v;
  endfunction

  vec_t tbl[19];

  initial begin
    int pulses;
    bus.key_valid = 1'b0; bus.bet_opcode = 6'd0; bus.color = 3'd0;
    bus.spin_done = 1'b0; bus.result_number = 6'd0;

    //           rst kv  op         col   sd  rn     we  slot data   cnt ph  win
    tbl[0]  = mk(0, 0, 6'd0,      3'd0, 0, 6'd0,  0, 4'd0, 8'h00, 4'd0, 2'd0, 6'd0);
    tbl[1]  = mk(1, 0, 6'd0,      3'd0, 0, 6'd0,  0, 4'd0, 8'h00, 4'd0, 2'd0, 6'd0);
    tbl[2]  = mk(1, 1, 6'd1,      3'd2, 0, 6'd0,  1, 4'd0, 8'h81, 4'd1, 2'd0, 6'd0);
    tbl[3]  = mk(1, 1, 6'd2,      3'd2, 0, 6'd0,  1, 4'd1, 8'h82, 4'd2, 2'd0, 6'd0);
    tbl[4]  = mk(1, 1, 6'd3,      3'd2, 0, 6'd0,  1, 4'd2, 8'h83, 4'd3, 2'd0, 6'd0);
    tbl[5]  = mk(1, 0, 6'd0,      3'd0, 0, 6'd0,  0, 4'd0, 8'h00, 4'd3, 2'd0, 6'd0);
    tbl[6]  = mk(1, 1, 6'd5,      3'd0, 0, 6'd0,  0, 4'd0, 8'h00, 4'd3, 2'd0, 6'd0);
    tbl[7]  = mk(1, 1, OPC_SPIN,  3'd0, 0, 6'd0,  0, 4'd0, 8'h00, 4'd3, 2'd1, 6'd0);
    tbl[8]  = mk(1, 0, 6'd0,      3'd0, 1, 6'd17, 0, 4'd0, 8'h00, 4'd3, 2'd2, 6'd17);
    tbl[9]  = mk(1, 0, 6'd0,      3'd0, 1, 6'd5,  0, 4'd0, 8'h00, 4'd3, 2'd2, 6'd17);
    tbl[10] = mk(1, 0, 6'd0,      3'd0, 0, 6'd0,  0, 4'd0, 8'h00, 4'd3, 2'd2, 6'd17);
    tbl[11] = mk(1, 1, 6'd9,      3'd1, 0, 6'd0,  0, 4'd0, 8'h00, 4'd3, 2'd2, 6'd17);
    tbl[12] = mk(1, 0, 6'd0,      3'd0, 0, 6'd0,  0, 4'd0, 8'h00, 4'd3, 2'd3, 6'd17);
    tbl[13] = mk(1, 0, 6'd0,      3'd0, 0, 6'd0,  0, 4'd0, 8'h00, 4'd0, 2'd0, 6'd17);
    tbl[14] = mk(1, 1, OPC_SPIN,  3'd2, 0, 6'd0,  0, 4'd0, 8'h00, 4'd0, 2'd0, 6'd17);
    tbl[15] = mk(1, 1, 6'd7,      3'd1, 0, 6'd0,  1, 4'd0, 8'h47, 4'd1, 2'd0, 6'd17);
    tbl[16] = mk(1, 1, OPC_SPIN,  3'd0, 0, 6'd0,  0, 4'd0, 8'h00, 4'd1, 2'd1, 6'd17);
    tbl[17] = mk(1, 1, 6'd4,      3'd2, 0, 6'd0,  0, 4'd0, 8'h00, 4'd1, 2'd1, 6'd17);
    tbl[18] = mk(0, 0, 6'd0,      3'd0, 0, 6'd0,  0, 4'd0, 8'h00, 4'd0, 2'd0, 6'd0);

    for (int i = 0; i < 19; i++) begin
      apply(tbl[i].rst_n, tbl[i].kv, tbl[i].op, tbl[i].col, tbl[i].sd, tbl[i].rn);
      check($sformatf("tbl%0d", i), 32'(observe(tbl[i].e_we)),
            32'(expect_obs(tbl[i].e_we, tbl[i].e_slot, tbl[i].e_data,
                           tbl[i].e_cnt, tbl[i].e_ph, tbl[i].e_win)));
    end

    // Thirteen bets against twelve slots: the last one must be dropped.
    apply(1, 0, 6'd0, 3'd0, 0, 6'd0);
    for (int i = 0; i < 13; i++) begin
      apply(1, 1, 6'(i + 10), 3'(1 + i % 7), 0, 6'd0);
      check_model($sformatf("fill%0d", i));
    end
    check("sat_count", 32'(bus.bet_count), 32'd12);
    check("sat_no_we", 32'(bus.bet_we), 32'd0);
    apply(1, 1, OPC_CLEAR, 3'd3, 0, 6'd0);
    check("clr_full_pulse", 32'(bus.bets_clear), 32'd1);
    apply(1, 0, 6'd0, 3'd0, 0, 6'd0);
    check("clr_full_count", 32'({bus.bet_count, bus.phase}), 32'h00);

    // Five bets, a chipless bet, then an abort: exactly one clear pulse.
    for (int i = 0; i < 5; i++) apply(1, 1, 6'(i + 20), 3'd4, 0, 6'd0);
    check("five_count", 32'(bus.bet_count), 32'd5);
    apply(1, 1, 6'd30, 3'd0, 0, 6'd0);
    check("nochip_we", 32'({bus.bet_we, bus.bet_count}), 32'h05);
    apply(1, 1, OPC_CLEAR, 3'd5, 0, 6'd0);
    pulses = int'(bus.bets_clear);
    for (int i = 0; i < 3; i++) begin
      apply(1, 0, 6'd0, 3'd0, 0, 6'd0);
      pulses += int'(bus.bets_clear);
    end
    check("abort_pulses", 32'(pulses), 32'd1);
    check("abort_count", 32'(bus.bet_count), 32'd0);

    // Reset while spinning abandons the round without a clear pulse.
    apply(1, 1, 6'd8, 3'd6, 0, 6'd0);
    apply(1, 1, OPC_SPIN, 3'd0, 0, 6'd0);
    check("spin_req_up", 32'(bus.spin_req), 32'd1);
    apply(0, 0, 6'd0, 3'd0, 0, 6'd0);
    check("rst_in_spin", 32'(observe(1'b1)), 32'd0);

    // Random traffic against the model.
    apply(1, 0, 6'd0, 3'd0, 0, 6'd0);
    for (int i = 0; i < 3000; i++) begin
      logic [5:0] op;
      int r;
      op = 6'($urandom_range(0, 63));
      r  = $urandom_range(0, 99);
      if (r < 8)       op = OPC_SPIN;
      else if (r < 10) op = OPC_CLEAR;
      apply(($urandom_range(0, 299) != 0), ($urandom_range(0, 1) == 1), op,
            3'($urandom_range(0, 7)), ($urandom_range(0, 7) == 0),
            6'($urandom_range(0, 63)));
      check_model($sformatf("rnd%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule

// File: doc/roulette_round_sequencer.md
# roulette_round_sequencer

Sequences one roulette round around the shared bet-latch and spin datapath: accepts validated keyboard/Arduino bets into twelve slots, hands the locked bet set to the processor with a spin request, captures the winning LED number, holds it for display, then clears the slots for the next round. It sits between the PS/2 decode path (`keyboardToBet`, `Ps2Controller`) and the regfile's `spin_check`/bet inputs, replacing ad-hoc counter and latch logic with one FSM owner.

## Interface
- `MAX_BETS`, 12: bet slots available per round (1..15).
- `OPC_SPIN`, 6'b111110: opcode that requests a spin.
- `OPC_CLEAR`, 6'b111111: opcode that aborts the round and clears bets.
- `HOLD_CYCLES`, 100_000_000: cycles the result is held in RESULT before auto-clear (≥1).
- `SPIN_TIMEOUT`, 200_000_000: watchdog limit in SPIN (used only with `ROUND_TIMEOUT_EN`).

- `clock` input 1: single system clock; all logic on posedge.
- `reset` input 1: synchronous, active-low reset.
- `key_valid` input 1: one-cycle pulse, new decoded key present.
- `bet_opcode` input 6: decoded bet opcode, valid with `key_valid`.
- `color` input 3: Arduino chip colour; 3'b000 = no chip.
- `spin_done` input 1: one-cycle pulse from processor, result valid.
- `result_number` input 6: winning pocket, sampled on `spin_done`.
- `bet_we` output 1: one-cycle write strobe into slot `bet_slot`.
- `bet_slot` output 4: slot index 0..MAX_BETS-1.
- `bet_data` output 8: `{color[1:0], bet_opcode}`.
- `bet_count` output 4: bets accepted this round.
- `spin_req` output 1: level, high throughout SPIN (drives `spin_check`).
- `bets_clear` output 1: one-cycle pulse clearing all slots.
- `win_number` output 6: latched winning pocket.
- `phase` output 2: 0=BET, 1=SPIN, 2=RESULT, 3=CLEAR.
- `timeout_err` output 1: sticky; set on watchdog expiry, cleared on next accepted bet or reset.

## Operation
- States: BET, SPIN, RESULT, CLEAR; `phase` encodes current state.
- BET:
  - Accept on `key_valid` when opcode ∉ {OPC_SPIN, OPC_CLEAR}, `color`≠0 and `bet_count`<MAX_BETS.
  - Following cycle: `bet_we`=1, `bet_slot`=old count, `bet_data` as sampled, `bet_count`+1.
  - Bets at MAX_BETS, bets with `color`=0, and any key outside BET are dropped silently.
  - `key_valid` with OPC_SPIN: if `bet_count`≥1, go to SPIN; otherwise ignore.
  - `key_valid` with OPC_CLEAR: go to CLEAR.
- SPIN:
  - `spin_req`=1.
  - On `spin_done`, latch `result_number` into `win_number`, load hold counter, go to RESULT.
- RESULT: hold counter decrements each cycle; at 0 go to CLEAR. `win_number` remains stable.
- CLEAR: `bets_clear`=1 for exactly one cycle, `bet_count`←0, then BET. `win_number` keeps its value until the next `spin_done`.
- `bet_count` saturates at MAX_BETS and never wraps.

## Timing
- Reset values (`reset`=0 at a clock edge): state BET, `bet_we`=0, `bet_slot`=0, `bet_data`=0, `bet_count`=0, `spin_req`=0, `bets_clear`=0, `win_number`=0, `timeout_err`=0, all counters 0.
- Reset mid-round abandons the round; no `bets_clear` pulse is issued.
- Bet acceptance latency: `key_valid` at cycle N gives `bet_we` at N+1.
- Spin key at N: `spin_req` rises at N+1.
- `spin_done` at N: `spin_req` falls and `win_number` updates at N+1. `bets_clear` pulses at N+1+HOLD_CYCLES; BET resumes at N+2+HOLD_CYCLES.
- `spin_done` outside SPIN is ignored.
- Back-to-back `key_valid` pulses in BET are each accepted, one write per cycle.
- `key_valid`(OPC_CLEAR) in the same cycle as acceptance-eligible state: the clear wins, nothing is written.

## Configuration
- `ROUND_TIMEOUT_EN` defined:
  - A watchdog counts cycles in SPIN.
  - After SPIN_TIMEOUT cycles without `spin_done`: `timeout_err`←1, `win_number` unchanged, state goes to CLEAR.
- `ROUND_TIMEOUT_EN` undefined:
  - No watchdog; SPIN waits indefinitely.
  - `timeout_err` is tied to 0.

## Test plan
- Reset, then three bets (opcodes 1,2,3; color 3'b010) → `bet_we` pulses on slots 0,1,2 with `bet_data`=8'h81,8'h82,8'h83; `bet_count`=3.
- Thirteen bets with MAX_BETS=12 → twelve writes (slots 0..11), thirteenth dropped, `bet_count`=12. A bet with `color`=0 is never written.
- OPC_SPIN with `bet_count`=0 → stays BET, `spin_req`=0. After one bet, OPC_SPIN → `spin_req`=1 next cycle.
- Round completion: in SPIN, `spin_done` with `result_number`=6'd17 → `win_number`=17. With HOLD_CYCLES=4, `bets_clear` pulses 5 cycles after `spin_done`, then `bet_count`=0 and `phase`=0.
- OPC_CLEAR after 5 bets → one `bets_clear` pulse, `bet_count`=0. Reset low during SPIN → all outputs at reset values next cycle.
- With `ROUND_TIMEOUT_EN` and SPIN_TIMEOUT=8, no `spin_done` → `timeout_err`=1 after 8 cycles, then CLEAR. A subsequent accepted bet clears `timeout_err`.
